// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back controller for a register file with a single write port.
//
// Round-robin arbitration among NREQ write-back requesters feeds one registered
// write stage (w_reg/w_dat/write). A pending-write scoreboard with one bit per
// register lets issue logic detect read-after-write hazards on two read ports.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     per-requester handshake, ready is a combinational one-hot grant
//   req_reg, req_dat    packed per-requester destination register and data
//   w_reg, w_dat, write registered register-file write port
//   issue_valid/reg     destination of the instruction issuing this cycle
//   r_reg0, r_reg1      read addresses of the issuing instruction
//   hazard0, hazard1    read address has a pending write (never for x0)
//   idle                no pending writes and no write in flight
//
// Optional feature (macro WB_BYPASS_EN): adds fwd_dat0/fwd_dat1 and forwards the
// in-flight write data, suppressing the matching hazard for that cycle.

module wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_reg,
  input  logic [NREQ*DW-1:0]   req_dat,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        w_reg,
  output logic [DW-1:0]        w_dat,
  output logic                 write,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_reg,
  input  logic [AW-1:0]        r_reg0,
  input  logic [AW-1:0]        r_reg1,
  output logic                 hazard0,
  output logic                 hazard1,
  output logic                 idle
`ifdef WB_BYPASS_EN
  ,
  output logic [DW-1:0]        fwd_dat0,
  output logic [DW-1:0]        fwd_dat1
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 1 << AW;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_dat;
  logic [NR-1:0] pend;

  // Walk requesters starting at the pointer, wrapping modulo NREQ; first valid wins.
  always_comb begin : arb
    int idx;
    idx       = 0;
    req_ready = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any        = 1'b1;
        gnt_idx        = PW'(idx);
        req_ready[idx] = 1'b1;
      end
    end
  end

  assign sel_reg = req_reg[gnt_idx*AW +: AW];
  assign sel_dat = req_dat[gnt_idx*DW +: DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // A grant to x0 is consumed but never becomes a register-file write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg <= '0;
      w_dat <= '0;
      write <= 1'b0;
    end else begin
      write <= gnt_any && (sel_reg != '0);
      if (gnt_any) begin
        w_reg <= sel_reg;
        w_dat <= sel_dat;
      end
    end
  end

  // Clear on commit first, then set on issue, so a same-edge set for the
  // same register survives: the newer instruction owns the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      logic [NR-1:0] nxt;
      nxt = pend;
      if (write) nxt[w_reg] = 1'b0;
      if (issue_valid && (issue_reg != '0)) nxt[issue_reg] = 1'b1;
      pend <= nxt;
    end
  end

  always_comb begin
    hazard0 = (r_reg0 != '0) && pend[r_reg0];
    hazard1 = (r_reg1 != '0) && pend[r_reg1];
`ifdef WB_BYPASS_EN
    fwd_dat0 = '0;
    fwd_dat1 = '0;
    if (write && (w_reg == r_reg0) && (r_reg0 != '0)) begin
      hazard0  = 1'b0;
      fwd_dat0 = w_dat;
    end
    if (write && (w_reg == r_reg1) && (r_reg1 != '0)) begin
      hazard1  = 1'b0;
      fwd_dat1 = w_dat;
    end
`endif
  end

  assign idle = (pend == '0) && !write;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back controller for the 32x32 register file, which has a single write port.
- Arbitrates round-robin among NREQ write-back requesters (ALU, load unit, mul/div) and drives the register-file write port through one registered stage.
- Keeps a pending-write scoreboard. Issue logic uses it to stall on read-after-write hazards for the two read ports.

Parameters:
- NREQ, 3, number of write-back requesters (2..8).
- DW, 32, data width.
- AW, 5, register address width (2**AW registers).

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has a write-back pending
- req_reg  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_dat  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant, combinational; the transfer occurs when valid & ready
- w_reg  out  AW  register-file write address (registered)
- w_dat  out  DW  register-file write data (registered)
- write  out  1  register-file write enable (registered)
- issue_valid  in  1  an instruction with a destination register issues this cycle
- issue_reg  in  AW  destination of the issuing instruction
- r_reg0  in  AW  read-port 0 address being issued
- r_reg1  in  AW  read-port 1 address being issued
- hazard0  out  1  r_reg0 has a pending write (combinational)
- hazard1  out  1  r_reg1 has a pending write (combinational)
- idle  out  1  no pending writes and write==0

Behaviour:
- Reset (async, rst_n=0):
  - write=0, w_reg=0, w_dat=0.
  - Round-robin pointer=0.
  - Scoreboard all clear.
  - idle=1 once write=0 and the scoreboard is clear.
- Arbitration:
  - Search starts at the pointer and wraps modulo NREQ; the first requester with req_valid set gets req_ready=1.
  - At most one req_ready is high. req_ready is 0 for requesters whose req_valid=0.
  - No ready→valid dependency; requesters must not wait for ready before asserting valid.
  - On a grant to requester g, the pointer becomes (g+1) mod NREQ on the next edge.
  - With no valid requests the pointer holds.
- Output stage: one-cycle latency.
  - A grant at edge t loads w_reg/w_dat from the winner; write=1 during cycle t+1.
  - With no grant, write=0 on the next cycle; w_reg/w_dat hold their last values.
- Register x0: a granted request with req_reg==0 is accepted (ready=1) but produces write=0 and does not touch the scoreboard.
- Scoreboard: pend[2**AW], one bit per register.
  - Set on issue_valid when issue_reg!=0.
  - Cleared when the output stage commits (write=1 at the edge) for w_reg.
  - Set and clear of the same register at the same edge: the set wins, because the newer instruction owns it.
- Hazard outputs:
  - hazard0 = pend[r_reg0]; hazard1 = pend[r_reg1].
  - Neither hazard output ever asserts for x0.
  - Issue logic must stall while either output is high.
- Starvation bound: a requester holding valid is granted within NREQ cycles.
- Reset mid-operation: an in-flight output-stage write is dropped (write=0 immediately) and the scoreboard is cleared. The pipeline is flushed by reset, so this is expected.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined:
  - Adds outputs fwd_dat0 and fwd_dat1 (DW each).
  - If write=1 and w_reg==r_reg0!=0, then hazard0=0 and fwd_dat0=w_dat. Same rule for port 1 with r_reg1 and fwd_dat1.
  - This removes one stall cycle. Otherwise fwd_dat equals 0.
  - Issue logic muxes fwd_dat in place of register-file data when the matching hazard is suppressed.
- When undefined:
  - The fwd_dat ports are absent.
  - The hazard outputs are pure scoreboard lookups.

Test Plan:
- Reset with rst_n=0 mid-write (write=1, w_reg=7) -> write=0 immediately, idle=1, hazard0=0 for r_reg0=7.
- All three requesters valid for 6 cycles, dest regs 1/2/3 -> grants 0,1,2,0,1,2; write=1 on each following cycle with w_reg sequence 1,2,3,1,2,3.
- issue_valid with issue_reg=5, then r_reg0=5 -> hazard0=1 until the cycle after requester 1 writes reg 5 with data 0xDEADBEEF; w_dat=0xDEADBEEF in the commit cycle, hazard0=0 afterwards.
- Commit of reg 9 in the same cycle as issue_valid with issue_reg=9 -> pend[9] remains 1 and hazard1=1 for r_reg1=9.
- Request to x0 with data 0x1234 -> req_ready=1, write stays 0, hazards for r_reg0=0 stay 0.
- WB_BYPASS_EN: write=1 with w_reg=4, w_dat=0xA5A5A5A5, r_reg1=4 pending -> hazard1=0 and fwd_dat1=0xA5A5A5A5 in that cycle.
